gs_row_update: RTL and testbench



---
 rtl/gs_pkg.sv | 21 ++
 rtl/gs_mac.sv | 33 +++
 rtl/gs_row_update.sv | 128 ++++++++++++
 tb/tb_gs_row_update.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared fixed-point formats, widths and FSM states for the Gauss-Seidel row update.
package gs_pkg;

  localparam int FRAC_X = 16;
  localparam int FRAC_R = 30;
  localparam int COEF_W = 8;
  localparam int X_W    = 32;
  localparam int B_W    = 16;

  localparam logic signed [X_W-1:0] MAX_X = 32'sh7FFF_FFFF;
  localparam logic signed [X_W-1:0] MIN_X = 32'sh8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_WAIT_R,
    S_MUL,
    S_SAT
  } state_t;

endpackage

// File: rtl/gs_mac.sv
// Registered signed multiply-subtract accumulator: acc <= acc - coef*xj,
// or acc <= b << FRAC_X when a new row is loaded.
module gs_mac
  import gs_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic signed [B_W-1:0]   b,
  input  logic                    sub_en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [X_W-1:0]   xj,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [COEF_W+X_W-1:0] term;

  assign term = coef * xj;

  // b is an integer, so it enters the accumulator already aligned to Q.16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(b) << FRAC_X;
    end else if (sub_en) begin
      acc <= acc - ACC_W'(term);
    end
  end

endmodule

// File: rtl/gs_row_update.sv
// One Gauss-Seidel row update: x_new = (b - sum a_ij*x_j) * (1/a_ii), Q16.16 out.
// Define GS_ROW_SAT_EN to clamp the result to the 32-bit signed range instead of wrapping.
module gs_row_update
  import gs_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 48
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_b,
  input  logic        i_coef_valid,
  input  logic [7:0]  i_coef,
  input  logic [31:0] i_xj,
  output logic        o_coef_ready,
  input  logic        i_recip_valid,
  input  logic [31:0] i_recip,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_x_new
);

  localparam int CNT_W = $clog2(N);
  localparam int PW    = ACC_W + X_W;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic                     recip_got;
  logic signed [X_W-1:0]    recip;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     q;
  logic [X_W-1:0]           result;
  logic                     take;
  logic                     load;
  logic                     last;
  logic                     cap;

  assign take = i_coef_valid && (state == S_ACC);
  assign load = i_start && (state == S_IDLE);
  assign last = take && (count == CNT_W'(N - 2));
  assign cap  = ((state == S_ACC) || (state == S_WAIT_R)) && !recip_got && i_recip_valid;

  assign o_busy       = (state != S_IDLE);
  assign o_coef_ready = (state == S_ACC);

  gs_mac #(.ACC_W(ACC_W)) mac (
    .clk    (i_clk),
    .reset  (i_reset),
    .load   (load),
    .b      ($signed(i_b)),
    .sub_en (take),
    .coef   ($signed(i_coef)),
    .xj     ($signed(i_xj)),
    .acc    (acc)
  );

  // Q.46 product back to Q.16; arithmetic shift floors toward -inf.
  assign q = prod >>> FRAC_R;

`ifdef GS_ROW_SAT_EN
  always_comb begin
    result = q[X_W-1:0];
    if (q > PW'(MAX_X)) begin
      result = MAX_X;
    end else if (q < PW'(MIN_X)) begin
      result = MIN_X;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{q[PW-1:X_W], prod[FRAC_R-1:0]};
  assign result = q[X_W-1:0];
`endif

  // A reciprocal arriving together with the last pair counts as already captured.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      count     <= '0;
      recip_got <= 1'b0;
      recip     <= '0;
      prod      <= '0;
      o_valid   <= 1'b0;
      o_x_new   <= '0;
    end else begin
      o_valid <= 1'b0;
      if (cap) begin
        recip     <= $signed(i_recip);
        recip_got <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state     <= S_ACC;
            count     <= '0;
            recip_got <= 1'b0;
          end
        end
        S_ACC: begin
          if (take) begin
            count <= count + 1'b1;
            if (last) begin
              state <= (recip_got || i_recip_valid) ? S_MUL : S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (i_recip_valid) begin
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= PW'(acc) * PW'(recip);
          state <= S_SAT;
        end
        S_SAT: begin
          o_x_new <= result;
          o_valid <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_row_update.sv
// Bench for gs_row_update (N=4): directed table rows, reset corner case and
// randomized rows checked against a wide-integer reference model.
module tb_gs_row_update;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [15:0] i_b;
  logic        i_coef_valid;
  logic [7:0]  i_coef;
  logic [31:0] i_xj;
  logic        o_coef_ready;
  logic        i_recip_valid;
  logic [31:0] i_recip;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_x_new;

  int checks = 0;
  int errors = 0;

  gs_row_update #(.N(4), .ACC_W(48)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_b           (i_b),
    .i_coef_valid  (i_coef_valid),
    .i_coef        (i_coef),
    .i_xj          (i_xj),
    .o_coef_ready  (o_coef_ready),
    .i_recip_valid (i_recip_valid),
    .i_recip       (i_recip),
    .o_busy        (o_busy),
    .o_valid       (o_valid),
    .o_x_new       (o_x_new)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string            name;
    logic [15:0]      b;
    logic [2:0][7:0]  c;
    logic [2:0][31:0] x;
    logic [31:0]      r;
    int               rdelay;
    bit               gaps;
    bit               spam;
    logic [31:0]      expv;
  } vec_t;

  vec_t tbl[5];

  task automatic check_output(input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", what, got, want);
    end
  endtask

  // Real-valued rule evaluated in 128-bit integers: no accumulator modelling needed.
  function automatic logic [31:0] model(input logic [15:0] b, input logic [2:0][7:0] c,
                                        input logic [2:0][31:0] x, input logic [31:0] r);
    logic signed [127:0] acc;
    logic signed [127:0] p;
    logic signed [127:0] q;
    acc = 128'($signed(b)) * 65536;
    for (int i = 0; i < 3; i++) begin
      acc = acc - 128'($signed(c[i])) * 128'($signed(x[i]));
    end
    p = acc * 128'($signed(r));
    q = p >>> 30;
`ifdef GS_ROW_SAT_EN
    if (q > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (q < -128'sh8000_0000) return 32'h8000_0000;
`endif
    return q[31:0];
  endfunction

  task automatic apply_stimulus(input vec_t v);
    int k;
    int cyc;
    int lat;
    int ready_bad;
    int wait_bad;
    bit vld;
    if (v.rdelay < 0) begin
      i_recip_valid = 1'b1;
      i_recip = v.r;
    end else begin
      i_recip_valid = 1'b0;
      i_recip = $urandom;
    end
    i_b = v.b;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    k = 0;
    cyc = 0;
    ready_bad = 0;
    while (k < 3 && cyc < 50) begin
      vld = v.gaps ? (cyc % 2 == 0) : 1'b1;
      i_coef_valid = vld;
      i_coef = vld ? v.c[k] : 8'($urandom);
      i_xj   = vld ? v.x[k] : $urandom;
      if (v.spam) i_start = (cyc % 2 == 1);
      if (v.rdelay < 0 && cyc >= 1) i_recip = $urandom;
      if (o_coef_ready !== 1'b1) ready_bad++;
      @(posedge i_clk); #1;
      if (vld) k++;
      cyc++;
    end
    i_coef_valid = 1'b0;
    i_start = 1'b0;
    check_output({v.name, "_pairs"}, 32'(k), 32'd3);
    check_output({v.name, "_ready_in_acc"}, 32'(ready_bad), 32'd0);
    if (v.rdelay >= 0) begin
      wait_bad = 0;
      for (int d = 0; d < v.rdelay; d++) begin
        if (o_coef_ready !== 1'b0 || o_busy !== 1'b1 || o_valid !== 1'b0) wait_bad++;
        @(posedge i_clk); #1;
      end
      check_output({v.name, "_wait_r_hold"}, 32'(wait_bad), 32'd0);
      i_recip_valid = 1'b1;
      i_recip = v.r;
      @(posedge i_clk); #1;
      i_recip = $urandom;
    end
    lat = 0;
    while (!o_valid && lat < 10) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check_output({v.name, "_latency"}, 32'(lat), 32'd2);
    check_output({v.name, "_x_new"}, o_x_new, v.expv);
    check_output({v.name, "_busy_at_valid"}, 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    check_output({v.name, "_valid_pulse"}, 32'(o_valid), 32'd0);
    check_output({v.name, "_x_held"}, o_x_new, v.expv);
    i_recip_valid = 1'b0;
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{"basic", 16'd10, {8'd1, 8'd1, 8'd1}, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
               32'h2000_0000, -1, 1'b0, 1'b0, 32'h0003_8000};
    tbl[1] = '{"wait_r", 16'd10, {8'd1, 8'd1, 8'd1}, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
               32'h2000_0000, 5, 1'b0, 1'b0, 32'h0003_8000};
    tbl[2] = '{"negative", 16'hFFFA, {8'hFE, 8'hFE, 8'hFE}, {32'h0001_8000, 32'h0001_8000, 32'h0001_8000},
               32'hC000_0000, -1, 1'b0, 1'b0, 32'hFFFD_0000};
`ifdef GS_ROW_SAT_EN
    tbl[3] = '{"overflow", 16'd0, {8'h80, 8'h80, 8'h80}, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
               32'h4000_0000, -1, 1'b0, 1'b0, 32'h7FFF_FFFF};
`else
    tbl[3] = '{"overflow", 16'd0, {8'h80, 8'h80, 8'h80}, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
               32'h4000_0000, -1, 1'b0, 1'b0, 32'hFFFF_FE80};
`endif
    tbl[4] = '{"gaps_spam", 16'd10, {8'd1, 8'd1, 8'd1}, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
               32'h2000_0000, -1, 1'b1, 1'b1, 32'h0003_8000};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_b = '0;
    i_coef_valid = 1'b0;
    i_coef = '0;
    i_xj = '0;
    i_recip_valid = 1'b0;
    i_recip = '0;
    #12;
    check_output("reset_busy", 32'(o_busy), 32'd0);
    check_output("reset_ready", 32'(o_coef_ready), 32'd0);
    check_output("reset_valid", 32'(o_valid), 32'd0);
    check_output("reset_x_new", o_x_new, 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    for (int t = 0; t < 5; t++) apply_stimulus(tbl[t]);

    // Reset in the middle of a row, after two of three pairs.
    i_recip_valid = 1'b1;
    i_recip = 32'h2000_0000;
    i_b = 16'd10;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_coef_valid = 1'b1;
    i_coef = 8'd1;
    i_xj = 32'h0001_0000;
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    i_coef_valid = 1'b0;
    i_reset = 1'b1;
    #1;
    check_output("midreset_busy", 32'(o_busy), 32'd0);
    check_output("midreset_ready", 32'(o_coef_ready), 32'd0);
    check_output("midreset_valid", 32'(o_valid), 32'd0);
    check_output("midreset_x_new", o_x_new, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_recip_valid = 1'b0;
    @(posedge i_clk); #1;
    apply_stimulus(tbl[0]);

    for (int t = 0; t < 20; t++) begin
      rv.name = $sformatf("rand%0d", t);
      rv.b = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
        rv.c[i] = 8'($urandom);
        rv.x[i] = (t % 2 == 0) ? $urandom : 32'($signed(20'($urandom)));
      end
      rv.r = (t % 2 == 0) ? $urandom : 32'($signed(24'($urandom)));
      rv.rdelay = int'($urandom_range(0, 4)) - 1;
      rv.gaps = 1'($urandom);
      rv.spam = 1'($urandom);
      rv.expv = model(rv.b, rv.c, rv.x, rv.r);
      apply_stimulus(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
